// File: rtl/s_axil_regbank.sv
// s_axil_regbank: AXI4-Lite slave register bank with N_RW byte-strobed
// control registers at word 0.., and N_RO status registers at RO_BASE...
// It generates per-register write and read pulses.
// It returns SLVERR for writes to status registers and DECERR for unmapped
// words.
// Optional feature macro: S_AXIL_REGBANK_SNAPSHOT_EN. When it is defined, a
// read of word RO_BASE freezes every status input into a shadow bank, and
// later reads of the other status words return that coherent copy.
//
// Write FSM states:
//   state      | meaning
//   WR_IDLE    | waiting for AW and W; both readys high
//   WR_HAVE_AW | address latched, waiting for W data
//   WR_HAVE_W  | data latched, waiting for AW address
//   WR_RESP    | write executed, bvalid high until bready
module s_axil_regbank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int N_RW       = 4,
  parameter int N_RO       = 16,
  parameter int RO_BASE    = 16,
  localparam int STRB_W    = DATA_WIDTH / 8,
  localparam int BYTE_SH   = $clog2(STRB_W),
  localparam int AW        = ADDR_WIDTH + BYTE_SH
) (
  input  logic                         axi_clock,
  input  logic                         rst,
  output logic [N_RW*DATA_WIDTH-1:0]   rw_regs,
  output logic [N_RW-1:0]              wr_pulse,
  input  logic [N_RO*DATA_WIDTH-1:0]   ro_regs,
  output logic [N_RO-1:0]              rd_pulse,
  input  logic [AW-1:0]                s_axil_awaddr,
  input  logic [2:0]                   s_axil_awprot,
  input  logic                         s_axil_awvalid,
  output logic                         s_axil_awready,
  input  logic [DATA_WIDTH-1:0]        s_axil_wdata,
  input  logic [STRB_W-1:0]            s_axil_wstrb,
  input  logic                         s_axil_wvalid,
  output logic                         s_axil_wready,
  output logic [1:0]                   s_axil_bresp,
  output logic                         s_axil_bvalid,
  input  logic                         s_axil_bready,
  input  logic [AW-1:0]                s_axil_araddr,
  input  logic [2:0]                   s_axil_arprot,
  input  logic                         s_axil_arvalid,
  output logic                         s_axil_arready,
  output logic [DATA_WIDTH-1:0]        s_axil_rdata,
  output logic [1:0]                   s_axil_rresp,
  output logic                         s_axil_rvalid,
  input  logic                         s_axil_rready
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_RESP} wr_state_e;

  wr_state_e                    wr_state_q, wr_state_d;
  logic [ADDR_WIDTH-1:0]        aw_word_q, aw_word_d;
  logic [DATA_WIDTH-1:0]        wdata_q, wdata_d;
  logic [STRB_W-1:0]            wstrb_q, wstrb_d;
  logic                         awready_q, awready_d;
  logic                         wready_q, wready_d;
  logic                         bvalid_q, bvalid_d;
  logic [1:0]                   bresp_q, bresp_d;
  logic [N_RW*DATA_WIDTH-1:0]   rw_q, rw_d;
  logic [N_RW-1:0]              wr_pulse_q, wr_pulse_d;
  logic [N_RO*DATA_WIDTH-1:0]   ro_q;
  logic [DATA_WIDTH-1:0]        rdata_q, rdata_d;
  logic [1:0]                   rresp_q, rresp_d;
  logic                         rvalid_q, rvalid_d;
  logic [N_RO-1:0]              rd_pulse_q, rd_pulse_d;
`ifdef S_AXIL_REGBANK_SNAPSHOT_EN
  logic [N_RO*DATA_WIDTH-1:0]   shadow_q, shadow_d;
`endif

  logic                         aw_fire, w_fire, ar_fire, wr_exec;
  logic [31:0]                  wr_word, rd_word;
  logic [DATA_WIDTH-1:0]        rd_hit_data;
  logic [1:0]                   rd_hit_resp;
  logic [N_RO-1:0]              rd_hit_pulse;
  logic                         unused_ok;

  assign unused_ok = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr};

  assign aw_fire = s_axil_awvalid & awready_q;
  assign w_fire  = s_axil_wvalid & wready_q;
  assign ar_fire = s_axil_arvalid & s_axil_arready;

  // The executing write uses the live beat if it handshakes now, else the latched one.
  assign wr_word = 32'(aw_fire ? s_axil_awaddr[AW-1:BYTE_SH] : aw_word_q);
  assign rd_word = 32'(s_axil_araddr[AW-1:BYTE_SH]);

  // Write FSM, byte-strobed register update and B response.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_word_d  = aw_word_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rw_d       = rw_q;
    wr_pulse_d = '0;
    wr_exec    = 1'b0;
    if (aw_fire) aw_word_d = s_axil_awaddr[AW-1:BYTE_SH];
    if (w_fire) begin
      wdata_d = s_axil_wdata;
      wstrb_d = s_axil_wstrb;
    end
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_fire && w_fire) wr_exec = 1'b1;
        else if (aw_fire)      wr_state_d = WR_HAVE_AW;
        else if (w_fire)       wr_state_d = WR_HAVE_W;
      end
      WR_HAVE_AW: if (w_fire)  wr_exec = 1'b1;
      WR_HAVE_W:  if (aw_fire) wr_exec = 1'b1;
      WR_RESP: begin
        if (s_axil_bready) begin
          wr_state_d = WR_IDLE;
          bvalid_d   = 1'b0;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
    if (wr_exec) begin
      wr_state_d = WR_RESP;
      bvalid_d   = 1'b1;
      bresp_d    = RESP_DECERR;
      for (int k = 0; k < N_RW; k++) begin
        if (wr_word == 32'(k)) begin
          bresp_d       = RESP_OKAY;
          wr_pulse_d[k] = 1'b1;
          for (int b = 0; b < STRB_W; b++) begin
            if (wstrb_d[b]) rw_d[k*DATA_WIDTH + b*8 +: 8] = wdata_d[b*8 +: 8];
          end
        end
      end
      if (wr_word >= 32'(RO_BASE) && wr_word < 32'(RO_BASE + N_RO)) bresp_d = RESP_SLVERR;
    end
    awready_d = (wr_state_d == WR_IDLE) || (wr_state_d == WR_HAVE_W);
    wready_d  = (wr_state_d == WR_IDLE) || (wr_state_d == WR_HAVE_AW);
  end

  // Read address decode; RW reads see the pre-write register value.
  always_comb begin
    rd_hit_data  = '0;
    rd_hit_resp  = RESP_DECERR;
    rd_hit_pulse = '0;
    for (int k = 0; k < N_RW; k++) begin
      if (rd_word == 32'(k)) begin
        rd_hit_data = rw_q[k*DATA_WIDTH +: DATA_WIDTH];
        rd_hit_resp = RESP_OKAY;
      end
    end
    for (int k = 0; k < N_RO; k++) begin
      if (rd_word == 32'(RO_BASE + k)) begin
        rd_hit_resp     = RESP_OKAY;
        rd_hit_pulse[k] = 1'b1;
`ifdef S_AXIL_REGBANK_SNAPSHOT_EN
        rd_hit_data = (k == 0) ? ro_q[k*DATA_WIDTH +: DATA_WIDTH]
                               : shadow_q[k*DATA_WIDTH +: DATA_WIDTH];
`else
        rd_hit_data = ro_q[k*DATA_WIDTH +: DATA_WIDTH];
`endif
      end
    end
  end

  // R channel: load on AR handshake, hold until rready.
  always_comb begin
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rvalid_d   = rvalid_q;
    rd_pulse_d = '0;
`ifdef S_AXIL_REGBANK_SNAPSHOT_EN
    shadow_d   = shadow_q;
    if (ar_fire && rd_word == 32'(RO_BASE)) shadow_d = ro_q;
`endif
    if (ar_fire) begin
      rdata_d    = rd_hit_data;
      rresp_d    = rd_hit_resp;
      rvalid_d   = 1'b1;
      rd_pulse_d = rd_hit_pulse;
    end else if (s_axil_rready) begin
      rvalid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge axi_clock) begin
    if (rst) begin
      wr_state_q <= WR_IDLE;
      aw_word_q  <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b1;
      wready_q   <= 1'b1;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rw_q       <= '0;
      wr_pulse_q <= '0;
      ro_q       <= '0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rd_pulse_q <= '0;
`ifdef S_AXIL_REGBANK_SNAPSHOT_EN
      shadow_q   <= '0;
`endif
    end else begin
      wr_state_q <= wr_state_d;
      aw_word_q  <= aw_word_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rw_q       <= rw_d;
      wr_pulse_q <= wr_pulse_d;
      ro_q       <= ro_regs;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rvalid_q   <= rvalid_d;
      rd_pulse_q <= rd_pulse_d;
`ifdef S_AXIL_REGBANK_SNAPSHOT_EN
      shadow_q   <= shadow_d;
`endif
    end
  end

  assign rw_regs        = rw_q;
  assign wr_pulse       = wr_pulse_q;
  assign rd_pulse       = rd_pulse_q;
  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = ~rvalid_q | s_axil_rready;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rvalid  = rvalid_q;

endmodule
